// File: rtl/sub_shift_stage_if.sv
// Handshake and S-box bus for sub_shift_stage.
// The master side drives start/state_in and supplies the substituted byte
// coming back from the external sbytes S-box. The slave side is the stage itself.
interface sub_shift_stage_if;
  logic         start;
  logic [127:0] state_in;
  logic [7:0]   sb_olddata;
  logic         sb_enable;
  logic [7:0]   sb_newdata;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  modport master (
    output start, state_in, sb_newdata,
    input  sb_olddata, sb_enable, busy, done, state_out
  );

  modport slave (
    input  start, state_in, sb_newdata,
    output sb_olddata, sb_enable, busy, done, state_out
  );
endinterface

// File: rtl/sub_shift_stage.sv
// Sequenced SubBytes + ShiftRows stage for an AES-128 round.
// It streams the 16 state bytes, one per cycle, through an external
// combinational S-box. It then applies ShiftRows and pulses done for one cycle.
// Byte i of a 128-bit state is bits [127-8i -: 8]. In the packed
// [15:0][7:0] view that is lane 15-i. Row = i%4, col = i/4.
module sub_shift_stage (
  input  logic               clk,
  input  logic               rst,
  sub_shift_stage_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SUB, SHIFT, DONE} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [15:0][7:0]     sbuf;
  logic [15:0][7:0]     shifted;
  logic [127:0]         state_out_q;
  logic                 done_q;
  logic [3:0]           lane;

  // Byte cnt lives in lane 15-cnt of the packed buffer.
  assign lane = 4'd15 - cnt;

  // ShiftRows is pure wiring: out(r,c) = buf(r,(c+r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[15-(4*c+r)] = sbuf[15-(4*((c+r)%4)+r)];
    end
  end

  // S-box drive is only live in SUB. Elsewhere the bus is parked at zero.
  assign bus.sb_enable  = (state == SUB);
  assign bus.sb_olddata = (state == SUB) ? sbuf[lane] : 8'h00;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.state_out  = state_out_q;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sbuf        <= '0;
      state_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sbuf  <= bus.state_in;
            cnt   <= 4'd0;
            state <= SUB;
          end
        end
        SUB: begin
          sbuf[lane] <= bus.sb_newdata;
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd15) state <= SHIFT;
        end
        SHIFT: begin
          state_out_q <= shifted;
          done_q      <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // The edge that ends the done cycle also accepts a new start.
          // This gives the 18-cycle back-to-back throughput.
          done_q <= 1'b0;
          if (bus.start) begin
            sbuf  <= bus.state_in;
            cnt   <= 4'd0;
            state <= SUB;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Self-checking bench for sub_shift_stage.
// It provides an AES S-box stand-in for the sbytes block. It also holds a
// byte-array reference model of SubBytes + ShiftRows.
module tb_sub_shift_stage;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clk = 1'b0;
  logic rst;
  sub_shift_stage_if bus ();

  sub_shift_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Combinational S-box, as the real sbytes block behaves.
  assign bus.sb_newdata = SBOX[bus.sb_olddata];

  int errors = 0;
  int checks = 0;
  int last_lat;
  int en_cnt;
  logic [7:0] seq [16];

  // Reference: substitute every byte, then out(r,c) = sub(r,(c+r)%4).
  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0] b [16];
    logic [7:0] o [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = b[4*((c+r)%4)+r];
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res;
  endfunction

  // Issue one start and wait for done. Returns at the negedge of the done cycle.
  // When inject is set, start is pulsed mid-SUB with a different state.
  task automatic run_op(input logic [127:0] s, input bit inject, input logic [127:0] s_alt);
    int n;
    bit seen;
    bus.state_in = s;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.state_in = {$urandom, $urandom, $urandom, $urandom};
    n = 0; en_cnt = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      if (bus.sb_enable) begin
        if (en_cnt < 16) seq[en_cnt] = bus.sb_olddata;
        en_cnt++;
      end
      if (bus.done) seen = 1'b1;
      else begin
        if (inject && n == 4) begin
          bus.start = 1'b1;
          bus.state_in = s_alt;
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n++;
      end
    end
    last_lat = seen ? n : -1;
  endtask

  // The cycle after done must have done low again.
  task automatic check_done_falls(input string name);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b required done=0 busy=0", name, bus.done, bus.busy);
    end
  endtask

  task automatic check_op(input string name, input logic [127:0] exp);
    checks++;
    if (last_lat !== 17) begin
      errors++;
      $display("FAIL %s latency: got %0d required 17", name, last_lat);
    end
    checks++;
    if (bus.state_out !== exp) begin
      errors++;
      $display("FAIL %s state_out: got %h required %h", name, bus.state_out, exp);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state_out !== 128'h0 ||
        bus.sb_enable !== 1'b0 || bus.sb_olddata !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b en=%b old=%h out=%h required all zero",
               bus.busy, bus.done, bus.sb_enable, bus.sb_olddata, bus.state_out);
    end
  endtask

  task automatic test_all_zero;
    run_op(128'h0, 1'b0, 128'h0);
    check_op("all_zero", {16{8'h63}});
    check_done_falls("all_zero");
  endtask

  task automatic test_all_ones;
    run_op({16{8'hff}}, 1'b0, 128'h0);
    check_op("all_ones", {16{8'h16}});
    check_done_falls("all_ones");
  endtask

  task automatic test_fips;
    logic [127:0] s;
    logic [7:0] exp_b;
    bit bad;
    s = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    run_op(s, 1'b0, 128'h0);
    check_op("fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    checks++;
    if (en_cnt !== 16) begin
      errors++;
      $display("FAIL fips sb_enable_cycles: got %0d required 16", en_cnt);
    end
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_b = s[127-8*k -: 8];
      if (seq[k] !== exp_b) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fips sb_olddata_seq: first bytes %h %h %h required 19 3d e3", seq[0], seq[1], seq[2]);
    end
    check_done_falls("fips");
  endtask

  task automatic test_byte_order;
    logic [127:0] r;
    logic [7:0] b [16];
    run_op(128'h4300ff7461000000_0000000000000000, 1'b0, 128'h0);
    r = bus.state_out;
    for (int i = 0; i < 16; i++) b[i] = r[127-8*i -: 8];
    checks++;
    if (b[0] !== 8'h1a || b[1] !== 8'h63 || b[2] !== 8'h63 || b[3] !== 8'h63 ||
        b[7] !== 8'h92 || b[13] !== 8'h63 || b[10] !== 8'h16) begin
      errors++;
      $display("FAIL byte_order: out0=%h out1=%h out2=%h out3=%h out7=%h out13=%h out10=%h required 1a 63 63 63 92 63 16",
               b[0], b[1], b[2], b[3], b[7], b[13], b[10]);
    end
    check_done_falls("byte_order");
  endtask

  task automatic test_random;
    logic [127:0] s;
    for (int t = 0; t < 4; t++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_op(s, 1'b0, 128'h0);
      check_op("random", model(s));
      check_done_falls("random");
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] a, alt, b2;
    int m;
    a   = {$urandom, $urandom, $urandom, $urandom};
    alt = ~a;
    b2  = {$urandom, $urandom, $urandom, $urandom};
    run_op(a, 1'b1, alt);
    check_op("busy_ignore", model(a));
    // Start B during the done cycle so that it is sampled at E18.
    bus.start = 1'b1;
    bus.state_in = b2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    m = 1;
    while (m < 40 && bus.done !== 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      m++;
    end
    checks++;
    if (m !== 18) begin
      errors++;
      $display("FAIL back_to_back spacing: got %0d required 18", m);
    end
    checks++;
    if (bus.state_out !== model(b2)) begin
      errors++;
      $display("FAIL back_to_back state_out: got %h required %h", bus.state_out, model(b2));
    end
    check_done_falls("back_to_back");
  endtask

  task automatic test_reset_mid;
    logic [127:0] s;
    s = {$urandom, $urandom, $urandom, $urandom};
    bus.state_in = s;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state_out !== 128'h0 || bus.sb_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b en=%b out=%h required 0 0 0 0",
               bus.busy, bus.done, bus.sb_enable, bus.state_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(s, 1'b0, 128'h0);
    check_op("after_reset", model(s));
    check_done_falls("after_reset");
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.state_in = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_all_zero;
    test_all_ones;
    test_fips;
    test_byte_order;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
